// File: rtl/hwpf_nl_issue_ctrl.sv
// Next-line prefetch sequencer: filters miss-driven candidates, records them
// in the history FIFO and issues them one at a time with a response timeout.
module hwpf_nl_issue_ctrl #(
    parameter int ADDR_WIDTH = 40,
    parameter int LINE_BITS  = 6,
    parameter int HIST_DEPTH = 8,
    parameter int PEND_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic [1:0]            acc_valid_i,
    input  logic [1:0]            acc_miss_i,
    input  logic [ADDR_WIDTH-1:0] acc_addr_i [2],
    input  logic [ADDR_WIDTH-1:0] hist_data_i [HIST_DEPTH],
    input  logic [HIST_DEPTH-1:0] hist_valid_i,
    output logic [1:0]            hist_take_o,
    output logic [ADDR_WIDTH-1:0] hist_addr_o [2],
    output logic                  hist_lock_o,
    output logic                  hist_flush_o,
    output logic                  pf_req_valid_o,
    output logic [ADDR_WIDTH-1:0] pf_req_addr_o,
    input  logic                  pf_req_ready_i,
    input  logic                  pf_rsp_valid_i,
    output logic                  busy_o,
    output logic [15:0]           drop_cnt_o
);

    localparam int IW = ADDR_WIDTH - LINE_BITS;
    localparam int PW = $clog2(PEND_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pend_q [PEND_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [TW-1:0]         timer;
    logic [15:0]           drop_cnt;

    logic [PEND_DEPTH-1:0] pend_vld;
    logic [ADDR_WIDTH-1:0] cand [2];
    logic [1:0]            raw;
    logic [1:0]            top;
    logic [1:0]            dup;
    logic [1:0]            surv;
    logic                  inflight;
    logic                  pop;
    logic [CW-1:0]         free;
    logic                  en0;
    logic                  en1;
    logic [1:0]            n_enq;
    logic [1:0]            n_drop;
    logic [1:0]            lane_take;
    logic [ADDR_WIDTH-1:0] lane_addr [2];
    logic [16:0]           drop_sum;

    // Slot p holds a live entry when it lies within count slots of rd_ptr.
    always_comb begin
        for (int p = 0; p < PEND_DEPTH; p++) begin
            pend_vld[p] = CW'(PW'(p) - rd_ptr) < count;
        end
    end

    assign inflight = (state == S_REQ) || (state == S_WAIT);
    assign pop = (state == S_IDLE) && enable_i && (count != '0) && !flush_i;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            raw[i]  = acc_valid_i[i] && acc_miss_i[i] && enable_i && !flush_i;
            top[i]  = &acc_addr_i[i][ADDR_WIDTH-1:LINE_BITS];
            cand[i] = {acc_addr_i[i][ADDR_WIDTH-1:LINE_BITS] + IW'(1),
                       {LINE_BITS{1'b0}}};
            dup[i]  = inflight && (cand[i] == req_addr);
            for (int h = 0; h < HIST_DEPTH; h++) begin
                if (hist_valid_i[h] && hist_data_i[h] == cand[i]) dup[i] = 1'b1;
            end
            for (int p = 0; p < PEND_DEPTH; p++) begin
                if (pend_vld[p] && pend_q[p] == cand[i]) dup[i] = 1'b1;
            end
        end
        if (raw[0] && cand[0] == cand[1]) dup[1] = 1'b1;
        surv = raw & ~top & ~dup;
    end

    // The IDLE pop frees its slot before this cycle's candidates claim one.
    always_comb begin
        free   = CW'(PEND_DEPTH) - count + CW'(pop);
        en0    = surv[0] && (free != '0);
        en1    = surv[1] && (free > CW'(en0));
        n_enq  = {1'b0, en0} + {1'b0, en1};
        n_drop = {1'b0, surv[0] && !en0} + {1'b0, surv[1] && !en1};
        lane_take    = 2'b00;
        lane_addr[0] = '0;
        lane_addr[1] = '0;
        if (en0) begin
            lane_take[0] = 1'b1;
            lane_addr[0] = cand[0];
            if (en1) begin
                lane_take[1] = 1'b1;
                lane_addr[1] = cand[1];
            end
        end else if (en1) begin
            lane_take[0] = 1'b1;
            lane_addr[0] = cand[1];
        end
        drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            req_addr <= '0;
            timer    <= '0;
            drop_cnt <= '0;
            for (int p = 0; p < PEND_DEPTH; p++) pend_q[p] <= '0;
        end else begin
            if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (lane_take[0]) pend_q[wr_ptr] <= lane_addr[0];
                if (lane_take[1]) pend_q[wr_ptr + PW'(1)] <= lane_addr[1];
                wr_ptr <= wr_ptr + PW'(n_enq);
                rd_ptr <= rd_ptr + PW'(pop);
                count  <= count + CW'(n_enq) - CW'(pop);
            end
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        req_addr <= pend_q[rd_ptr];
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (pf_req_ready_i) begin
                        timer <= TW'(TIMEOUT);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pf_rsp_valid_i || timer == '0 || flush_i) state <= S_IDLE;
                    else timer <= timer - TW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        hist_take_o    = rst_i ? 2'b00 : lane_take;
        hist_addr_o[0] = rst_i ? '0 : lane_addr[0];
        hist_addr_o[1] = rst_i ? '0 : lane_addr[1];
    end

    assign hist_lock_o    = !enable_i && !rst_i;
    assign hist_flush_o   = flush_i && !rst_i;
    assign pf_req_valid_o = (state == S_REQ);
    assign pf_req_addr_o  = req_addr;
    assign busy_o         = (state != S_IDLE) || (count != '0);
    assign drop_cnt_o     = drop_cnt;

endmodule

// File: tb/tb_hwpf_nl_issue_ctrl.sv
// Directed bench for hwpf_nl_issue_ctrl: filter vectors from a table plus
// hand sequences for latency, stall/drop, timeout, flush and reset.
module tb_hwpf_nl_issue_ctrl;

    localparam int AW = 40;
    localparam int HD = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic          flush_i;
    logic [1:0]    acc_valid_i;
    logic [1:0]    acc_miss_i;
    logic [AW-1:0] acc_addr_i [2];
    logic [AW-1:0] hist_data_i [HD];
    logic [HD-1:0] hist_valid_i;
    logic [1:0]    hist_take_o;
    logic [AW-1:0] hist_addr_o [2];
    logic          hist_lock_o;
    logic          hist_flush_o;
    logic          pf_req_valid_o;
    logic [AW-1:0] pf_req_addr_o;
    logic          pf_req_ready_i;
    logic          pf_rsp_valid_i;
    logic          busy_o;
    logic [15:0]   drop_cnt_o;

    int checks = 0;
    int errors = 0;

    hwpf_nl_issue_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
        .acc_valid_i(acc_valid_i), .acc_miss_i(acc_miss_i),
        .acc_addr_i(acc_addr_i), .hist_data_i(hist_data_i),
        .hist_valid_i(hist_valid_i), .hist_take_o(hist_take_o),
        .hist_addr_o(hist_addr_o), .hist_lock_o(hist_lock_o),
        .hist_flush_o(hist_flush_o), .pf_req_valid_o(pf_req_valid_o),
        .pf_req_addr_o(pf_req_addr_o), .pf_req_ready_i(pf_req_ready_i),
        .pf_rsp_valid_i(pf_rsp_valid_i), .busy_o(busy_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [1:0]    vld;
        logic [1:0]    miss;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [AW-1:0] h0;
        logic          hv;
        logic [1:0]    take;
        logic [AW-1:0] e0;
        logic [AW-1:0] e1;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        acc_valid_i = 2'b00;
        acc_miss_i  = 2'b00;
        acc_addr_i[0] = '0;
        acc_addr_i[1] = '0;
        flush_i = 1'b0;
    endtask

    task automatic miss(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        acc_valid_i = v;
        acc_miss_i  = v;
        acc_addr_i[0] = a0;
        acc_addr_i[1] = a1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        enable_i = 1'b1;
        idle_inputs();
        for (int h = 0; h < HD; h++) hist_data_i[h] = '0;
        hist_valid_i = '0;
        pf_req_ready_i = 1'b0;
        pf_rsp_valid_i = 1'b0;
        next();
        next();
        rst_i = 1'b0;
    endtask

    task automatic wait_req(input string nm, input logic [AW-1:0] exp);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            settle();
            if (pf_req_valid_o) begin
                found = 1'b1;
                chk(nm, pf_req_addr_o, exp);
            end
            next();
        end
        chk({nm, "_seen"}, found, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        //        en  vld    miss   a0               a1              h0        hv  take   e0               e1
        tbl[0]  = '{1, 2'b01, 2'b01, 40'h1000,        40'h0,        40'h0,    0, 2'b01, 40'h1040,        40'h0};
        tbl[1]  = '{1, 2'b11, 2'b11, 40'h2000,        40'h2010,     40'h0,    0, 2'b01, 40'h2040,        40'h0};
        tbl[2]  = '{1, 2'b01, 2'b01, 40'h3000,        40'h0,        40'h3040, 1, 2'b00, 40'h0,           40'h0};
        tbl[3]  = '{1, 2'b01, 2'b01, 40'h3000,        40'h0,        40'h3040, 0, 2'b01, 40'h3040,        40'h0};
        tbl[4]  = '{1, 2'b11, 2'b11, 40'h4000,        40'h5000,     40'h0,    0, 2'b11, 40'h4040,        40'h5040};
        tbl[5]  = '{1, 2'b10, 2'b10, 40'h0,           40'h6000,     40'h0,    0, 2'b01, 40'h6040,        40'h0};
        tbl[6]  = '{1, 2'b01, 2'b00, 40'h1000,        40'h0,        40'h0,    0, 2'b00, 40'h0,           40'h0};
        tbl[7]  = '{0, 2'b11, 2'b11, 40'h4000,        40'h5000,     40'h0,    0, 2'b00, 40'h0,           40'h0};
        tbl[8]  = '{1, 2'b11, 2'b11, 40'hFF_FFFF_FFC0, 40'h7000,    40'h0,    0, 2'b01, 40'h7040,        40'h0};
        tbl[9]  = '{1, 2'b01, 2'b01, 40'hFF_FFFF_FF80, 40'h0,       40'h0,    0, 2'b01, 40'hFF_FFFF_FFC0, 40'h0};
        tbl[10] = '{1, 2'b10, 2'b11, 40'h1000,        40'h8000,     40'h0,    0, 2'b01, 40'h8040,        40'h0};
        tbl[11] = '{1, 2'b11, 2'b11, 40'h4000,        40'h5000,     40'h5040, 1, 2'b01, 40'h4040,        40'h0};

        // reset state, with a miss presented while reset is held
        do_reset();
        rst_i = 1'b1;
        miss(2'b01, 40'h1000, 40'h0);
        settle();
        chk("rst_take", hist_take_o, 2'b00);
        chk("rst_valid", pf_req_valid_o, 1'b0);
        chk("rst_addr", pf_req_addr_o, 40'h0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_drop", drop_cnt_o, 16'h0);
        next();
        idle_inputs();
        rst_i = 1'b0;

        foreach (tbl[v]) begin
            do_reset();
            enable_i = tbl[v].en;
            miss(tbl[v].vld, tbl[v].a0, tbl[v].a1);
            acc_miss_i = tbl[v].miss;
            hist_data_i[0] = tbl[v].h0;
            hist_valid_i[0] = tbl[v].hv;
            settle();
            chk($sformatf("v%0d_take", v), hist_take_o, tbl[v].take);
            chk($sformatf("v%0d_addr0", v), hist_addr_o[0], tbl[v].e0);
            chk($sformatf("v%0d_addr1", v), hist_addr_o[1], tbl[v].e1);
            chk($sformatf("v%0d_lock", v), hist_lock_o, !tbl[v].en);
            next();
            idle_inputs();
            settle();
            chk($sformatf("v%0d_busy", v), busy_o, tbl[v].take != 2'b00);
            next();
        end

        // latency: miss in N, request in N+2, response ends it
        do_reset();
        pf_req_ready_i = 1'b1;
        miss(2'b01, 40'h1000, 40'h0);
        settle();
        chk("lat_take", hist_take_o, 2'b01);
        chk("lat_haddr", hist_addr_o[0], 40'h1040);
        next();
        idle_inputs();
        settle();
        chk("lat_n1_valid", pf_req_valid_o, 1'b0);
        chk("lat_n1_busy", busy_o, 1'b1);
        next();
        settle();
        chk("lat_n2_valid", pf_req_valid_o, 1'b1);
        chk("lat_n2_addr", pf_req_addr_o, 40'h1040);
        next();
        settle();
        chk("lat_n3_valid", pf_req_valid_o, 1'b0);
        next();
        next();
        pf_rsp_valid_i = 1'b1;
        settle();
        chk("lat_wait_busy", busy_o, 1'b1);
        next();
        pf_rsp_valid_i = 1'b0;
        settle();
        chk("lat_done_busy", busy_o, 1'b0);
        next();

        // stall with overflow: A in register, B..E pending, F and G dropped
        do_reset();
        miss(2'b11, 40'h10000, 40'h20000);
        settle();
        chk("st_c0_take", hist_take_o, 2'b11);
        next();
        miss(2'b11, 40'h30000, 40'h40000);
        settle();
        chk("st_c1_take", hist_take_o, 2'b11);
        next();
        miss(2'b11, 40'h50000, 40'h60000);
        settle();
        chk("st_c2_take", hist_take_o, 2'b01);
        chk("st_c2_addr0", hist_addr_o[0], 40'h50040);
        chk("st_c2_addr1", hist_addr_o[1], 40'h0);
        chk("st_c2_drop", drop_cnt_o, 16'd0);
        next();
        miss(2'b01, 40'h70000, 40'h0);
        settle();
        chk("st_c3_take", hist_take_o, 2'b00);
        chk("st_c3_drop", drop_cnt_o, 16'd1);
        next();
        idle_inputs();
        for (int c = 4; c < 12; c++) begin
            settle();
            chk($sformatf("st_c%0d_valid", c), pf_req_valid_o, 1'b1);
            chk($sformatf("st_c%0d_addr", c), pf_req_addr_o, 40'h10040);
            next();
        end
        settle();
        chk("st_drop_final", drop_cnt_o, 16'd2);
        pf_req_ready_i = 1'b1;
        pf_rsp_valid_i = 1'b1;
        wait_req("st_req_a", 40'h10040);
        wait_req("st_req_b", 40'h20040);
        wait_req("st_req_c", 40'h30040);
        wait_req("st_req_d", 40'h40040);
        wait_req("st_req_e", 40'h50040);
        next();
        settle();
        chk("st_drain_busy", busy_o, 1'b0);
        next();

        // reset asserted in WAIT clears every output at once
        pf_rsp_valid_i = 1'b0;
        miss(2'b01, 40'hB0000, 40'h0);
        next();
        idle_inputs();
        next();
        settle();
        chk("rw_req_valid", pf_req_valid_o, 1'b1);
        next();
        settle();
        chk("rw_wait_busy", busy_o, 1'b1);
        chk("rw_drop_kept", drop_cnt_o, 16'd2);
        rst_i = 1'b1;
        enable_i = 1'b0;
        flush_i = 1'b1;
        miss(2'b11, 40'hC0000, 40'hD0000);
        #1;
        chk("rw_busy", busy_o, 1'b0);
        chk("rw_drop", drop_cnt_o, 16'd0);
        chk("rw_addr", pf_req_addr_o, 40'h0);
        chk("rw_take", hist_take_o, 2'b00);
        chk("rw_haddr", hist_addr_o[0], 40'h0);
        chk("rw_flush", hist_flush_o, 1'b0);
        chk("rw_lock", hist_lock_o, 1'b0);
        next();

        // timeout: 256 WAIT cycles, then the next pending entry issues
        do_reset();
        pf_req_ready_i = 1'b1;
        miss(2'b11, 40'h90000, 40'hA0000);
        next();
        idle_inputs();
        next();
        settle();
        chk("to_req_a", pf_req_addr_o, 40'h90040);
        chk("to_req_a_valid", pf_req_valid_o, 1'b1);
        next();
        repeat (255) next();
        settle();
        chk("to_last_wait_valid", pf_req_valid_o, 1'b0);
        chk("to_last_wait_busy", busy_o, 1'b1);
        next();
        settle();
        chk("to_idle_valid", pf_req_valid_o, 1'b0);
        next();
        settle();
        chk("to_req_b_valid", pf_req_valid_o, 1'b1);
        chk("to_req_b", pf_req_addr_o, 40'hA0040);
        next();

        // flush in REQ with three pending entries
        do_reset();
        miss(2'b11, 40'hE0000, 40'hF0000);
        next();
        miss(2'b11, 40'h100000, 40'h110000);
        next();
        miss(2'b01, 40'h120000, 40'h0);
        flush_i = 1'b1;
        settle();
        chk("fl_hflush", hist_flush_o, 1'b1);
        chk("fl_take", hist_take_o, 2'b00);
        chk("fl_valid", pf_req_valid_o, 1'b1);
        next();
        idle_inputs();
        settle();
        chk("fl_hflush_off", hist_flush_o, 1'b0);
        chk("fl_hold_valid", pf_req_valid_o, 1'b1);
        chk("fl_hold_addr", pf_req_addr_o, 40'hE0040);
        pf_req_ready_i = 1'b1;
        next();
        flush_i = 1'b1;
        settle();
        chk("fl_wait_busy", busy_o, 1'b1);
        next();
        flush_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk($sformatf("fl_empty_%0d", c), busy_o, 1'b0);
            next();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
